// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared types, defaults and helpers for the round-robin mux arbiter
package rr_mux_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_DEF         = 8;
    localparam int R_DEF         = 3;
    localparam int MAX_BURST_DEF = 4;

    // (x + 1) mod n without a divider; x is always below n here
    function automatic int wrap_inc(input int x, input int n);
        return (x + 1 >= n) ? 0 : x + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority picker: first requester at or after ptr, modulo N
module rr_pick
    import rr_mux_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int R = R_DEF
) (
    input  logic [N-1:0] req,
    input  logic [R-1:0] ptr,
    output logic [R-1:0] winner,
    output logic         any_req
);

    int idx;

    // Scan from farthest to nearest so the closest requester to ptr wins
    always_comb begin
        winner  = ptr;
        any_req = |req;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                winner = idx[R-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving an N:1 mux select with bounded bursts
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int R         = R_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [R-1:0] sel,
    output logic [N-1:0] gnt,
    output logic         valid
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t        state;
    logic [R-1:0]  ptr;
    logic [R-1:0]  sel_next;
    logic [R-1:0]  pick_ptr;
    logic [R-1:0]  winner;
    logic [CW-1:0] cnt;
    logic          any_req;
    logic          accept;
    logic          last_beat;
    logic          release_grant;

    function automatic logic [N-1:0] onehot(input logic [R-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    assign sel_next = R'(wrap_inc(int'(sel), N));

    // While busy the picker is only consulted on release, when ptr becomes sel+1
    assign pick_ptr = (state == BUSY) ? sel_next : ptr;

    rr_pick #(
        .N(N),
        .R(R)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner),
        .any_req(any_req)
    );

    assign valid         = (state == BUSY) & req[sel];
    assign accept        = valid & ready;
    assign last_beat     = accept & (cnt == LAST_BEAT);
    assign release_grant = (state == BUSY) & (~req[sel] | last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= BUSY;
                        sel   <= winner;
                        gnt   <= onehot(winner);
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (release_grant) begin
                        ptr <= sel_next;
                        if (any_req) begin
                            sel <= winner;
                            gnt <= onehot(winner);
                            cnt <= '0;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
